// File: rtl/mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : mem_arbiter
// Description : Two-requester single-port memory arbiter (fetch vs accelerator)
//               with accelerator lock bursts and fetch starvation protection.
// Revision    : 1.0 - initial release
// ============================================================================
module mem_arbiter #(
    parameter int ADDR_W   = 19,
    parameter int DATA_W   = 19,
    parameter int MAX_WAIT = 4
) (
    input  logic              clk,
    input  logic              rst,
    // fetch requester
    input  logic              if_req_i,
    input  logic [ADDR_W-1:0] if_addr_i,
    output logic              if_gnt_o,
    output logic [DATA_W-1:0] if_rdata_o,
    output logic              if_valid_o,
    output logic              if_stall_o,
    // accelerator requester
    input  logic              acc_req_i,
    input  logic              acc_we_i,
    input  logic              acc_lock_i,
    input  logic [ADDR_W-1:0] acc_addr_i,
    input  logic [DATA_W-1:0] acc_wdata_i,
    output logic              acc_gnt_o,
    output logic [DATA_W-1:0] acc_rdata_o,
    output logic              acc_valid_o,
    // memory port
    output logic              mem_re_o,
    output logic              mem_we_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [DATA_W-1:0] mem_wdata_o,
    input  logic [DATA_W-1:0] mem_rdata_i
);

    typedef enum logic [0:0] {
        ST_ARB  = 1'b0,
        ST_LOCK = 1'b1
    } state_t;

    localparam logic       C_GNT_IF   = 1'b0;
    localparam logic       C_GNT_ACC  = 1'b1;
    localparam logic [3:0] C_MAX_WAIT = 4'(MAX_WAIT);

    state_t              state_q, state_d;
    logic                last_q, last_d;
    logic [3:0]          starve_q, starve_d;
    logic                pend_if_q, pend_acc_q;
    logic [DATA_W-1:0]   if_rdata_q, if_rdata_d;
    logic [DATA_W-1:0]   acc_rdata_q, acc_rdata_d;

    logic                force_if;
    logic                arb_mode;
    logic                if_gnt;
    logic                acc_gnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_ARB;
            last_q      <= C_GNT_ACC;
            starve_q    <= 4'd0;
            pend_if_q   <= 1'b0;
            pend_acc_q  <= 1'b0;
            if_rdata_q  <= '0;
            acc_rdata_q <= '0;
        end else begin
            state_q     <= state_d;
            last_q      <= last_d;
            starve_q    <= starve_d;
            pend_if_q   <= if_gnt;
            pend_acc_q  <= acc_gnt & ~acc_we_i;
            if_rdata_q  <= if_rdata_d;
            acc_rdata_q <= acc_rdata_d;
        end
    end

    always_comb begin
        if_gnt   = 1'b0;
        acc_gnt  = 1'b0;
        state_d  = state_q;
        force_if = if_req_i && (starve_q >= C_MAX_WAIT);
        // Dropping the lock hands the current cycle straight back to normal arbitration.
        arb_mode = (state_q == ST_ARB) || !acc_lock_i || force_if;

        if (force_if) begin
            if_gnt = 1'b1;
        end else if (arb_mode) begin
            if (if_req_i && acc_req_i) begin
                if (last_q == C_GNT_ACC) begin
                    if_gnt = 1'b1;
                end else begin
                    acc_gnt = 1'b1;
                end
            end else begin
                if_gnt  = if_req_i;
                acc_gnt = acc_req_i;
            end
        end else begin
            acc_gnt = acc_req_i;
        end

        if (arb_mode) begin
            state_d = (acc_gnt && acc_lock_i) ? ST_LOCK : ST_ARB;
        end

        last_d = last_q;
        if (if_gnt) begin
            last_d = C_GNT_IF;
        end else if (acc_gnt) begin
            last_d = C_GNT_ACC;
        end

        starve_d = 4'd0;
        if (if_req_i && !if_gnt) begin
            starve_d = (starve_q == 4'hF) ? starve_q : starve_q + 4'd1;
        end

        if_rdata_d  = pend_if_q  ? mem_rdata_i : if_rdata_q;
        acc_rdata_d = pend_acc_q ? mem_rdata_i : acc_rdata_q;
    end

    assign if_gnt_o    = if_gnt;
    assign acc_gnt_o   = acc_gnt;
    assign if_stall_o  = if_req_i & ~if_gnt;

    assign if_valid_o  = pend_if_q;
    assign acc_valid_o = pend_acc_q;
    assign if_rdata_o  = if_rdata_d;
    assign acc_rdata_o = acc_rdata_d;

    // Fetch never writes, so only the accelerator can source write data.
    assign mem_re_o    = if_gnt | (acc_gnt & ~acc_we_i);
    assign mem_we_o    = acc_gnt & acc_we_i;
    assign mem_addr_o  = if_gnt  ? if_addr_i  :
                         acc_gnt ? acc_addr_i : '0;
    assign mem_wdata_o = acc_gnt ? acc_wdata_i : '0;

endmodule
`default_nettype wire

// File: tb/tb_mem_arbiter.sv
`default_nettype none
// ============================================================================
// Module      : tb_mem_arbiter
// Description : Directed self-checking bench for mem_arbiter.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_mem_arbiter;

    localparam int ADDR_W = 19;
    localparam int DATA_W = 19;
    localparam logic [DATA_W-1:0] C_SCRAMBLE = 19'h15555;

    logic              clk = 1'b0;
    logic              rst = 1'b1;
    logic              if_req = 1'b0;
    logic [ADDR_W-1:0] if_addr = '0;
    logic              if_gnt, if_valid, if_stall;
    logic [DATA_W-1:0] if_rdata;
    logic              acc_req = 1'b0, acc_we = 1'b0, acc_lock = 1'b0;
    logic [ADDR_W-1:0] acc_addr = '0;
    logic [DATA_W-1:0] acc_wdata = '0;
    logic              acc_gnt, acc_valid;
    logic [DATA_W-1:0] acc_rdata;
    logic              mem_re, mem_we;
    logic [ADDR_W-1:0] mem_addr;
    logic [DATA_W-1:0] mem_wdata;
    logic [DATA_W-1:0] mem_rdata = '0;

    int n_tests = 0;
    int n_fail  = 0;

    mem_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .MAX_WAIT(4)) dut (
        .clk        (clk),
        .rst        (rst),
        .if_req_i   (if_req),
        .if_addr_i  (if_addr),
        .if_gnt_o   (if_gnt),
        .if_rdata_o (if_rdata),
        .if_valid_o (if_valid),
        .if_stall_o (if_stall),
        .acc_req_i  (acc_req),
        .acc_we_i   (acc_we),
        .acc_lock_i (acc_lock),
        .acc_addr_i (acc_addr),
        .acc_wdata_i(acc_wdata),
        .acc_gnt_o  (acc_gnt),
        .acc_rdata_o(acc_rdata),
        .acc_valid_o(acc_valid),
        .mem_re_o   (mem_re),
        .mem_we_o   (mem_we),
        .mem_addr_o (mem_addr),
        .mem_wdata_o(mem_wdata),
        .mem_rdata_i(mem_rdata)
    );

    always #5 clk = ~clk;

    // Memory model: read data is the address XOR a fixed pattern, one cycle later.
    always @(posedge clk) begin
        if (mem_re) mem_rdata <= mem_addr ^ C_SCRAMBLE;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic sample();
        @(negedge clk);
    endtask

    initial begin
        // reset state
        sample();
        check("rst_if_gnt",   32'(if_gnt),    32'h0);
        check("rst_acc_gnt",  32'(acc_gnt),   32'h0);
        check("rst_if_valid", 32'(if_valid),  32'h0);
        check("rst_if_rdata", 32'(if_rdata),  32'h0);
        check("rst_acc_rdata",32'(acc_rdata), 32'h0);
        tick();
        rst = 1'b0;

        // idle
        sample();
        check("idle_gnts",  32'({if_gnt, acc_gnt}), 32'h0);
        check("idle_strb",  32'({mem_re, mem_we}),  32'h0);
        check("idle_addr",  32'(mem_addr),          32'h0);
        check("idle_stall", 32'(if_stall),          32'h0);
        tick();

        // fetch-only read of 0x00010 -> data 0x15545
        if_req  = 1'b1;
        if_addr = 19'h00010;
        sample();
        check("if_gnt",      32'(if_gnt),   32'h1);
        check("if_mem_re",   32'(mem_re),   32'h1);
        check("if_mem_addr", 32'(mem_addr), 32'h00010);
        check("if_acc_gnt",  32'(acc_gnt),  32'h0);
        tick();
        if_req = 1'b0;
        sample();
        check("if_valid",    32'(if_valid), 32'h1);
        check("if_rdata",    32'(if_rdata), 32'h15545);
        tick();
        sample();
        check("if_valid_end",32'(if_valid), 32'h0);
        check("if_rdata_hold",32'(if_rdata),32'h15545);

        // contention, last grant was IF -> ACC, IF, ACC, IF
        tick();
        if_req   = 1'b1;
        acc_req  = 1'b1;
        acc_addr = 19'h00022;
        for (int k = 0; k < 4; k++) begin
            sample();
            check("alt_acc_gnt", 32'(acc_gnt),  32'((k % 2) == 0));
            check("alt_if_gnt",  32'(if_gnt),   32'((k % 2) == 1));
            check("alt_stall",   32'(if_stall), 32'((k % 2) == 0));
            if (k > 0) begin
                check("alt_acc_valid", 32'(acc_valid), 32'((k % 2) == 1));
                check("alt_if_valid",  32'(if_valid),  32'((k % 2) == 0));
            end
            tick();
        end
        if_req  = 1'b0;
        acc_req = 1'b0;
        sample();
        check("alt_if_valid_last", 32'(if_valid),  32'h1);
        check("alt_acc_rdata",     32'(acc_rdata), 32'h15577);

        // accelerator write
        tick();
        acc_req   = 1'b1;
        acc_we    = 1'b1;
        acc_addr  = 19'h7FFFF;
        acc_wdata = 19'h5A5A5;
        sample();
        check("wr_gnt",   32'(acc_gnt),   32'h1);
        check("wr_we",    32'(mem_we),    32'h1);
        check("wr_re",    32'(mem_re),    32'h0);
        check("wr_addr",  32'(mem_addr),  32'h7FFFF);
        check("wr_wdata", 32'(mem_wdata), 32'h5A5A5);
        tick();
        acc_req = 1'b0;
        acc_we  = 1'b0;
        sample();
        check("wr_no_valid",   32'(acc_valid), 32'h0);
        check("wr_rdata_hold", 32'(acc_rdata), 32'h15577);
        check("wr_idle_wdata", 32'(mem_wdata), 32'h0);

        // lock burst with starvation limit 4: IF, ACC x4, IF(forced), ACC
        tick();
        if_req   = 1'b1;
        acc_req  = 1'b1;
        acc_lock = 1'b1;
        acc_addr = 19'h00022;
        for (int k = 0; k < 7; k++) begin
            sample();
            check("lock_if_gnt",  32'(if_gnt),   32'(k == 0 || k == 5));
            check("lock_acc_gnt", 32'(acc_gnt),  32'(!(k == 0 || k == 5)));
            check("lock_stall",   32'(if_stall), 32'(!(k == 0 || k == 5)));
            tick();
        end
        if_req   = 1'b0;
        acc_req  = 1'b0;
        acc_lock = 1'b0;

        // reset mid-read: IF granted (lock released same cycle), then reset
        tick();
        if_req = 1'b1;
        sample();
        check("rr_if_gnt", 32'(if_gnt), 32'h1);
        tick();
        if_req = 1'b0;
        rst    = 1'b1;
        sample();
        check("rr_if_valid",  32'(if_valid),  32'h0);
        check("rr_if_rdata",  32'(if_rdata),  32'h0);
        check("rr_acc_rdata", 32'(acc_rdata), 32'h0);
        tick();
        rst     = 1'b0;
        if_req  = 1'b1;
        acc_req = 1'b1;
        sample();
        check("rr_post_if_gnt",  32'(if_gnt),   32'h1);
        check("rr_post_acc_gnt", 32'(acc_gnt),  32'h0);
        check("rr_post_valid",   32'(if_valid), 32'h0);
        tick();
        sample();
        check("rr_post2_acc_gnt", 32'(acc_gnt),  32'h1);
        check("rr_post2_valid",   32'(if_valid), 32'h1);
        tick();
        if_req  = 1'b0;
        acc_req = 1'b0;
        sample();
        check("end_idle", 32'({if_gnt, acc_gnt, mem_re, mem_we, if_stall}), 32'h0);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/mem_arbiter.md
MEM_ARBITER -- requirements
Module: mem_arbiter

Interface
REQ-001 Parameter ADDR_W, default 19, SHALL set address width of all address ports.
REQ-002 Parameter DATA_W, default 19, SHALL set width of all data ports.
REQ-003 Parameter MAX_WAIT, default 4, SHALL set the consecutive denied-cycle limit for the fetch requester (range 1..15).
REQ-004 clk  in  1  single clock; all state updates on rising edge.
REQ-005 rst  in  1  reset, asynchronous, active-high.
REQ-006 if_req  in  1  fetch read request, held until if_gnt.
REQ-007 if_addr  in  ADDR_W  fetch address.
REQ-008 if_gnt  out  1  fetch granted this cycle.
REQ-009 if_rdata  out  DATA_W  fetch read data.
REQ-010 if_valid  out  1  if_rdata valid, one-cycle pulse.
REQ-011 if_stall  out  1  fetch stage must hold its PC.
REQ-012 acc_req  in  1  accelerator request, held until acc_gnt.
REQ-013 acc_we  in  1  accelerator write (1) / read (0).
REQ-014 acc_lock  in  1  accelerator requests burst ownership.
REQ-015 acc_addr  in  ADDR_W  accelerator address.
REQ-016 acc_wdata  in  DATA_W  accelerator write data.
REQ-017 acc_gnt  out  1  accelerator granted this cycle.
REQ-018 acc_rdata  out  DATA_W  accelerator read data.
REQ-019 acc_valid  out  1  acc_rdata valid, one-cycle pulse (reads only).
REQ-020 mem_re, mem_we  out  1 each  memory strobes; mem_addr out ADDR_W; mem_wdata out DATA_W; mem_rdata in DATA_W, valid one cycle after mem_re.

Function
REQ-021 At most one of if_gnt/acc_gnt SHALL be high in any cycle; grants are combinational from current requests and registered state.
REQ-022 Granted requester's addr/we/wdata SHALL drive mem_addr/mem_we/mem_wdata in the grant cycle; mem_re = grant & !we; with no grant all strobes 0, mem_addr/mem_wdata 0.
REQ-023 Read data SHALL return in cycle N+1 for a grant in cycle N: owner of mem_rdata registered, valid pulse to that requester only; rdata ports otherwise hold last value.
REQ-024 FSM states: ARB, LOCK.
REQ-025 ARB, single request: grant it.
REQ-026 ARB, both request: grant requester not granted most recently (last_gnt register, reset value = ACC so IF wins first contention).
REQ-027 ARB -> LOCK when acc granted with acc_lock=1.
REQ-028 LOCK: acc_req granted every cycle it is asserted, if_req denied; LOCK -> ARB when acc_lock=0 (evaluated same cycle, grant then follows ARB rules) or starvation forces exit.
REQ-029 Starvation counter (4 bits): increments each cycle if_req=1 and if_gnt=0; clears when if_gnt=1 or if_req=0; saturates at 15.
REQ-030 Counter >= MAX_WAIT SHALL force if_gnt if if_req=1, in either state, and force LOCK -> ARB.
REQ-031 if_stall = if_req & !if_gnt (combinational).
REQ-032 last_gnt updates on every grant; unchanged in idle cycles.
REQ-033 Write grants SHALL produce no valid pulse.

Reset
REQ-034 rst=1 SHALL immediately force: state ARB, last_gnt ACC, counter 0, if_valid/acc_valid 0, if_rdata/acc_rdata 0, pending read owner cleared.
REQ-035 A read granted in the cycle before reset assertion SHALL produce no valid pulse after reset release.
REQ-036 First edge after rst deassertion SHALL behave as ARB with no history beyond REQ-034.

Verification
REQ-037 IF-only: if_req=1, if_addr=0x00010 -> if_gnt same cycle, mem_re=1, mem_addr=0x00010; next cycle if_valid=1, if_rdata=mem_rdata.
REQ-038 Contention: both req continuously, acc_lock=0 -> grants alternate IF, ACC, IF, ACC; if_stall=1 only in ACC cycles.
REQ-039 Lock: acc_lock=1, acc_req=1, if_req=1, MAX_WAIT=4 -> after IF wins first cycle, ACC granted 4 cycles, IF forced on 5th, if_stall high for exactly those 4 cycles.
REQ-040 Acc write: acc_we=1, addr 0x7FFFF, wdata 0x5A5A5 -> mem_we=1, mem_re=0, values driven; no acc_valid next cycle.
REQ-041 Reset mid-read: grant IF read, assert rst next cycle -> if_valid=0, if_rdata=0; after release, both req -> IF granted first.
REQ-042 Idle: no requests -> all grants/strobes 0, counter 0, if_stall=0.
